// File: rtl/aes_seq_pkg.sv
// Shared types and constants for the AES round sequencer front end.
// Holds the FSM state codes, key-size mode encodings, Nr constants and
// the mode -> Nr helpers used by the top.
package aes_seq_pkg;

  localparam int unsigned ROUND_W = 5;
  localparam int unsigned NR_W    = 4;
  localparam int unsigned MODE_W  = 2;
  localparam int unsigned STATE_W = 2;

  typedef logic [STATE_W-1:0] state_t;
  typedef logic [MODE_W-1:0]  mode_t;

  // Sequencer states
  localparam state_t ST_IDLE    = 2'd0;
  localparam state_t ST_ENCRYPT = 2'd1;
  localparam state_t ST_DECRYPT = 2'd2;
  localparam state_t ST_DONE    = 2'd3;

  // Key-size modes as latched (switch code 11 folds onto AES-128)
  localparam mode_t MODE_128 = 2'd0;
  localparam mode_t MODE_192 = 2'd1;
  localparam mode_t MODE_256 = 2'd2;

  localparam logic [NR_W-1:0] NR_128 = NR_W'(10);
  localparam logic [NR_W-1:0] NR_192 = NR_W'(12);
  localparam logic [NR_W-1:0] NR_256 = NR_W'(14);

  // Fold the raw switch code onto one of the three legal modes
  function automatic mode_t norm_mode(input logic [MODE_W-1:0] sw);
    return (sw == 2'b11) ? MODE_128 : mode_t'(sw);
  endfunction

  // Number of cipher rounds for a latched mode
  function automatic logic [NR_W-1:0] nr_of_mode(input mode_t m);
    case (m)
      MODE_192: return NR_192;
      MODE_256: return NR_256;
      default:  return NR_128;
    endcase
  endfunction

endpackage

// File: rtl/aes_round_sequencer_key_debounce.sv
// Pushbutton conditioner: synchroniser, debounce counter and press detect.
// Ports:
//   clk, rst  - system clock, async active-high reset
//   key_n     - raw active-low pushbutton (asynchronous, bouncy)
//   press     - registered one-cycle pulse on each debounced press
module key_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned SYNC_STAGES     = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n,
  output logic press
);

  localparam int unsigned CNT_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned FLUSH_W = $clog2(SYNC_STAGES + 1);
  localparam logic [CNT_W-1:0]   CNT_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [FLUSH_W-1:0] FLUSH_DONE = FLUSH_W'(SYNC_STAGES);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   synced;
  logic                   level;
  logic [CNT_W-1:0]       cnt;
  logic [FLUSH_W-1:0]     flush;
  logic                   armed;

  assign synced = sync_q[SYNC_STAGES-1];

  // Metastability synchroniser, reset to the released level
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], key_n};
    end
  end

  // Debounce and press detect. Presses are armed only once a genuine
  // released sample has been seen after reset, so a key held through
  // reset must be released before it can step the sequencer. The flush
  // counter skips the samples that are still the synchroniser reset value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level <= 1'b1;
      cnt   <= '0;
      flush <= '0;
      armed <= 1'b0;
      press <= 1'b0;
    end else begin
      press <= 1'b0;
      if (flush != FLUSH_DONE) begin
        flush <= flush + FLUSH_W'(1);
      end
      if ((flush == FLUSH_DONE) && synced && level) begin
        armed <= 1'b1;
      end
      if (synced == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        level <= synced;
        cnt   <= '0;
        press <= armed & ~synced;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/aes_round_sequencer.sv
// Debounced-pushbutton round sequencer for the AES demo top: walks the
// round counter through encrypt (1..Nr) then decrypt (Nr..2*Nr).
// Ports:
//   clk, rst    - system clock, async active-high reset
//   key_n       - raw active-low step pushbutton
//   sw_mode     - key-size switches, sampled on the first press of a run
//   step_pulse  - one-cycle strobe in the cycle round advances
//   round       - current round 0..2*nr
//   nr, mode    - latched Nr and key-size mode
//   enc_en      - round <= nr
//   dec_en      - round >= nr
//   done        - run complete, next press returns to idle
module aes_round_sequencer
  import aes_seq_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned SYNC_STAGES     = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               key_n,
  input  logic [MODE_W-1:0]  sw_mode,
  output logic               step_pulse,
  output logic [ROUND_W-1:0] round,
  output logic [NR_W-1:0]    nr,
  output logic [MODE_W-1:0]  mode,
  output logic               enc_en,
  output logic               dec_en,
  output logic               done
);

  logic press;

  state_t             state_q, state_d;
  logic [ROUND_W-1:0] round_d;
  logic [NR_W-1:0]    nr_d;
  mode_t              mode_d;
  logic               step_d, done_d, enc_d, dec_d;

  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .SYNC_STAGES    (SYNC_STAGES)
  ) u_key_debounce (
    .clk  (clk),
    .rst  (rst),
    .key_n(key_n),
    .press(press)
  );

  // State and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      round      <= '0;
      nr         <= NR_128;
      mode       <= MODE_128;
      step_pulse <= 1'b0;
      done       <= 1'b0;
      enc_en     <= 1'b1;
      dec_en     <= 1'b0;
    end else begin
      state_q    <= state_d;
      round      <= round_d;
      nr         <= nr_d;
      mode       <= mode_d;
      step_pulse <= step_d;
      done       <= done_d;
      enc_en     <= enc_d;
      dec_en     <= dec_d;
    end
  end

  // Next state and next output values
  always_comb begin
    state_d = state_q;
    round_d = round;
    nr_d    = nr;
    mode_d  = mode;
    step_d  = 1'b0;
    done_d  = done;
    if (press) begin
      case (state_q)
        ST_IDLE: begin
          mode_d  = norm_mode(sw_mode);
          nr_d    = nr_of_mode(mode_d);
          round_d = ROUND_W'(1);
          step_d  = 1'b1;
          state_d = (round_d == ROUND_W'(nr_d)) ? ST_DECRYPT : ST_ENCRYPT;
        end
        ST_ENCRYPT: begin
          round_d = round + ROUND_W'(1);
          step_d  = 1'b1;
          if (round_d == ROUND_W'(nr)) begin
            state_d = ST_DECRYPT;
          end
        end
        ST_DECRYPT: begin
          round_d = round + ROUND_W'(1);
          step_d  = 1'b1;
          if (round_d == {nr, 1'b0}) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end
        end
        default: begin
          round_d = '0;
          done_d  = 1'b0;
          state_d = ST_IDLE;
        end
      endcase
    end
    // Enables track the round value being registered alongside them
    enc_d = (round_d <= ROUND_W'(nr_d));
    dec_d = (round_d >= ROUND_W'(nr_d));
  end

endmodule
